// File: rtl/vending_pkg.sv
// Shared types, coin codes and coin valuation helpers for the parametrised vending controller.
package vending_pkg;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_CHANGE  = 1'b1
  } vm_state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A    = 2'b01;
  localparam logic [1:0] COIN_B    = 2'b10;
  localparam logic [1:0] COIN_C    = 2'b11;

  function automatic int coin_value(input logic [1:0] code, input int val_a,
                                    input int val_b, input int val_c);
    case (code)
      COIN_A:  return val_a;
      COIN_B:  return val_b;
      COIN_C:  return val_c;
      default: return 0;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vending_machine_param_if.sv
// Coin acceptor / dispenser signal bundle for the vending controller.
interface vending_machine_param_if #(
  parameter int CREDIT_W = 4
);
  logic [1:0]          coin;
  logic                cancel;
  logic                sell;
  logic                change;
  logic                coin_reject;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  modport master (output coin, cancel, input sell, change, coin_reject, busy, credit);
  modport slave  (input coin, cancel, output sell, change, coin_reject, busy, credit);
endinterface

// File: rtl/vm_change_counter.sv
// Remainder down-counter: loaded with units owed, emits one registered change pulse per decrement.
module vm_change_counter #(
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  input  logic                dec,
  output logic                change,
  output logic                last
);

  logic [CREDIT_W-1:0] cnt_q, cnt_d;
  logic                change_q, change_d;

  always_comb begin
    cnt_d    = cnt_q;
    change_d = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d    = cnt_q - CREDIT_W'(1);
      change_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      change_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      change_q <= change_d;
    end
  end

  assign change = change_q;
  assign last   = (cnt_q == CREDIT_W'(1));

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: accumulates coin credit, vends at PRICE and pays back
// change or cancel refunds one unit per cycle while rejecting coins.
module vending_machine_param
  import vending_pkg::*;
#(
  parameter int PRICE    = 3,
  parameter int VAL_A    = 1,
  parameter int VAL_B    = 2,
  parameter int VAL_C    = 0,
  parameter int CREDIT_W = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  vending_machine_param_if.slave  bus
);

  localparam int SUM_W   = CREDIT_W + 1;
  localparam int VAL_MAX = max3(VAL_A, VAL_B, VAL_C);

  // Credit never exceeds PRICE-1 in COLLECT, so this bound keeps every sum representable.
  if (PRICE < 1 || (PRICE - 1 + VAL_MAX) >= (1 << CREDIT_W)) begin : g_bad_cfg
    $error("vending_machine_param: PRICE/coin values do not fit in CREDIT_W");
  end

  vm_state_e           state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                sell_q, sell_d;
  logic                reject_q, reject_d;

  logic                load;
  logic [CREDIT_W-1:0] load_val;
  logic                dec;
  logic                change;
  logic                last;
  logic [SUM_W-1:0]    sum;
  logic                coin_seen;
  logic                coin_disabled;

  assign coin_seen     = (bus.coin != COIN_NONE);
  assign coin_disabled = (bus.coin == COIN_C) && (VAL_C == 0);
  assign sum           = SUM_W'(credit_q) + SUM_W'(coin_value(bus.coin, VAL_A, VAL_B, VAL_C));
  assign dec           = (state_q == ST_CHANGE);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    sell_d   = 1'b0;
    reject_d = 1'b0;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      ST_COLLECT: begin
        if (bus.cancel) begin
          reject_d = coin_seen;
          if (credit_q != '0) begin
            load     = 1'b1;
            load_val = credit_q;
            credit_d = '0;
            state_d  = ST_CHANGE;
          end
        end else if (coin_disabled) begin
          reject_d = 1'b1;
        end else if (sum >= SUM_W'(PRICE)) begin
          sell_d   = 1'b1;
          credit_d = '0;
          load     = 1'b1;
          load_val = CREDIT_W'(sum - SUM_W'(PRICE));
          if (load_val != '0) state_d = ST_CHANGE;
        end else begin
          credit_d = CREDIT_W'(sum);
        end
      end
      ST_CHANGE: begin
        reject_d = coin_seen;
        if (last) state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_COLLECT;
      credit_q <= '0;
      sell_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      sell_q   <= sell_d;
      reject_q <= reject_d;
    end
  end

  vm_change_counter #(.CREDIT_W(CREDIT_W)) u_change (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .change   (change),
    .last     (last)
  );

  assign bus.sell        = sell_q;
  assign bus.change      = change;
  assign bus.coin_reject = reject_q;
  assign bus.busy        = (state_q == ST_CHANGE);
  assign bus.credit      = credit_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench: three configurations driven with shared directed + random coin/cancel traffic,
// each checked every cycle against an "owed units" behavioural model.
module tb_vending_machine_param;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  vending_machine_param_if #(.CREDIT_W(4)) if0 ();
  vending_machine_param_if #(.CREDIT_W(4)) if1 ();
  vending_machine_param_if #(.CREDIT_W(4)) if2 ();

  vending_machine_param u0 (.clk(clk), .rstn(rstn), .bus(if0));
  vending_machine_param #(.PRICE(3), .VAL_C(6)) u1 (.clk(clk), .rstn(rstn), .bus(if1));
  vending_machine_param #(.PRICE(1), .VAL_C(6)) u2 (.clk(clk), .rstn(rstn), .bus(if2));

  int cfg_price [3] = '{3, 3, 1};
  int cfg_vc    [3] = '{0, 6, 6};

  int m_credit [3];
  int m_owed   [3];
  int m_sell   [3];
  int m_change [3];
  int m_rej    [3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // {sell, change, coin_reject, busy, credit[3:0]}
  function automatic logic [7:0] obs(input int k);
    case (k)
      0:       return {if0.sell, if0.change, if0.coin_reject, if0.busy, if0.credit};
      1:       return {if1.sell, if1.change, if1.coin_reject, if1.busy, if1.credit};
      default: return {if2.sell, if2.change, if2.coin_reject, if2.busy, if2.credit};
    endcase
  endfunction

  task automatic drive(input int c, input int x);
    if0.coin = 2'(c); if1.coin = 2'(c); if2.coin = 2'(c);
    if0.cancel = (x != 0); if1.cancel = (x != 0); if2.cancel = (x != 0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_credit[k] = 0; m_owed[k] = 0;
      m_sell[k] = 0; m_change[k] = 0; m_rej[k] = 0;
    end
  endtask

  task automatic model_edge(input int c, input int x);
    int val;
    for (int k = 0; k < 3; k++) begin
      m_sell[k] = 0; m_change[k] = 0; m_rej[k] = 0;
      val = (c == 1) ? 1 : (c == 2) ? 2 : (c == 3) ? cfg_vc[k] : 0;
      if (m_owed[k] > 0) begin
        m_change[k] = 1;
        m_owed[k]--;
        m_rej[k] = (c != 0);
      end else if (x != 0) begin
        m_rej[k]    = (c != 0);
        m_owed[k]   = m_credit[k];
        m_credit[k] = 0;
      end else if (c == 3 && cfg_vc[k] == 0) begin
        m_rej[k] = 1;
      end else if (m_credit[k] + val >= cfg_price[k]) begin
        m_sell[k]   = 1;
        m_owed[k]   = m_credit[k] + val - cfg_price[k];
        m_credit[k] = 0;
      end else begin
        m_credit[k] += val;
      end
    end
  endtask

  task automatic compare_all(input string ph);
    logic [7:0] o;
    for (int k = 0; k < 3; k++) begin
      o = obs(k);
      check_eq($sformatf("%s[%0d].sell", ph, k),   int'(o[7]),   m_sell[k]);
      check_eq($sformatf("%s[%0d].change", ph, k), int'(o[6]),   m_change[k]);
      check_eq($sformatf("%s[%0d].reject", ph, k), int'(o[5]),   m_rej[k]);
      check_eq($sformatf("%s[%0d].busy", ph, k),   int'(o[4]),   (m_owed[k] > 0) ? 1 : 0);
      check_eq($sformatf("%s[%0d].credit", ph, k), int'(o[3:0]), m_credit[k]);
    end
  endtask

  task automatic step(input int c, input int x, input string ph);
    @(negedge clk);
    drive(c, x);
    @(posedge clk);
    model_edge(c, x);
    #1;
    compare_all(ph);
  endtask

  // Asserted asynchronously wherever the caller is; outputs must clear without a clock edge.
  task automatic do_reset();
    rstn = 1'b0;
    drive(0, 0);
    #1;
    model_reset();
    compare_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [7:0] o;
    int c, x;
    rstn = 1'b1;
    drive(0, 0);
    #3;
    do_reset();

    // coin A then B at default price: credit 1, then exact vend
    step(1, 0, "t1a"); o = obs(0);
    check_eq("t1a.credit", int'(o[3:0]), 1);
    step(2, 0, "t1b"); o = obs(0);
    check_eq("t1b.sell", int'(o[7]), 1);
    check_eq("t1b.busy", int'(o[4]), 0);

    // B, B: vend with one unit of change
    step(2, 0, "t2a");
    step(2, 0, "t2b"); o = obs(0);
    check_eq("t2b.sell", int'(o[7]), 1);
    check_eq("t2b.busy", int'(o[4]), 1);
    step(0, 0, "t2c"); o = obs(0);
    check_eq("t2c.change", int'(o[6]), 1);
    check_eq("t2c.busy", int'(o[4]), 0);

    // cancel refund, then cancel with no credit
    step(1, 0, "t3a");
    step(0, 1, "t3b");
    step(0, 0, "t3c"); o = obs(0);
    check_eq("t3c.change", int'(o[6]), 1);
    check_eq("t3c.credit", int'(o[3:0]), 0);
    step(0, 1, "t3d"); o = obs(0);
    check_eq("t3d.quiet", int'(o), 0);

    // VAL_C=6 at price 3: three change pulses, coins held during them rejected
    repeat (6) step(0, 0, "drain");
    step(3, 0, "t4a"); o = obs(1);
    check_eq("t4a.sell", int'(o[7]), 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, "t4b"); o = obs(1);
      check_eq("t4b.change", int'(o[6]), 1);
      check_eq("t4b.reject", int'(o[5]), 1);
      check_eq("t4b.credit", int'(o[3:0]), 0);
    end

    // disabled denomination, then coin with cancel
    repeat (6) step(0, 0, "drain");
    step(3, 0, "t5a"); o = obs(0);
    check_eq("t5a.reject", int'(o[5]), 1);
    check_eq("t5a.credit", int'(o[3:0]), 0);
    step(1, 0, "t5b");
    step(1, 1, "t5c"); o = obs(0);
    check_eq("t5c.reject", int'(o[5]), 1);
    step(0, 0, "t5d"); o = obs(0);
    check_eq("t5d.change", int'(o[6]), 1);

    // price 1, coin C: reset after the second change pulse drops the rest
    repeat (8) step(0, 0, "drain");
    step(3, 0, "t6a");
    step(0, 0, "t6b");
    step(0, 0, "t6c"); o = obs(2);
    check_eq("t6c.change", int'(o[6]), 1);
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, "t6d"); o = obs(2);
      check_eq("t6d.change", int'(o[6]), 0);
    end

    for (int i = 0; i < 800; i++) begin
      c = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3));
      x = ($urandom_range(0, 7) == 0) ? 1 : 0;
      step(c, x, "rnd");
      if ($urandom_range(0, 199) == 0) begin
        #2;
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
